// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg : shared types for stream-handling blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stream_skid_state_t;

endpackage

`default_nettype wire

// File: rtl/std_stream_intf.sv
// ---------------------------------------------------------------------------
// std_stream_intf : valid/ready stream with a W-bit payload
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface std_stream_intf #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport in  (input  valid, input  payload, output ready);
  modport out (output valid, output payload, input  ready);
endinterface

`default_nettype wire

// File: rtl/stream_skid_buffer.sv
// ---------------------------------------------------------------------------
// stream_skid_buffer : two-entry skid buffer, all outputs straight from flops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_skid_buffer
  import stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  output logic [1:0]  count,
  std_stream_intf.in  stream_in,
  std_stream_intf.out stream_out
);

  localparam int c_W = $bits(stream_in.payload);

  stream_skid_state_t r_state;
  stream_skid_state_t w_next_state;
  logic               r_valid;
  logic               r_ready;
  logic [c_W-1:0]     r_main_q;
  logic [c_W-1:0]     r_skid_q;
  logic               w_in_x;
  logic               w_out_x;

  assign w_in_x  = stream_in.valid & r_ready;
  assign w_out_x = r_valid & stream_out.ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (w_in_x) w_next_state = BUSY;
      BUSY: begin
        if (w_in_x && !w_out_x)      w_next_state = FULL;
        else if (!w_in_x && w_out_x) w_next_state = EMPTY;
      end
      FULL:    if (w_out_x) w_next_state = BUSY;
      default: w_next_state = EMPTY;
    endcase
    if (flush) w_next_state = EMPTY;
  end

  // valid and ready are kept as their own flops so no decode sits on the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= (w_next_state != EMPTY);
      r_ready <= (w_next_state != FULL);
    end
  end

  // Payload storage needs no reset; flush/reset only invalidate it via r_state
  always_ff @(posedge clk) begin
    case (r_state)
      EMPTY: if (w_in_x) r_main_q <= stream_in.payload;
      BUSY: begin
        if (w_in_x && w_out_x) r_main_q <= stream_in.payload;
        else if (w_in_x)       r_skid_q <= stream_in.payload;
      end
      FULL:    if (w_out_x) r_main_q <= r_skid_q;
      default: ;
    endcase
  end

  assign stream_out.valid   = r_valid;
  assign stream_out.payload = r_main_q;
  assign stream_in.ready    = r_ready;
  assign count              = r_state;

endmodule

`default_nettype wire
